// File: rtl/poly_mul_pkg.sv
// Shared definitions for the polynomial multiplication scheduler.
//   phase_e      : scheduler phases, in the order a multiply walks them
//   BANK_*       : operand bank codes driven on src_bank
//   phase_ctrl_t : per-phase datapath controls (forward, element_wise, src_bank)
package poly_mul_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_NTT_A = 3'd1,
    PH_NTT_B = 3'd2,
    PH_PWMUL = 3'd3,
    PH_INTT  = 3'd4
  } phase_e;

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;

  localparam int DEFAULT_PHASE_TIMEOUT = 4095;

  typedef struct packed {
    logic       forward;
    logic       element_wise;
    logic [1:0] src_bank;
  } phase_ctrl_t;

  // Datapath controls that go with a phase; IDLE drives everything low.
  function automatic phase_ctrl_t phase_ctrl(input phase_e ph);
    phase_ctrl_t c;
    c = '0;
    case (ph)
      PH_NTT_A: begin
        c.forward  = 1'b1;
        c.src_bank = BANK_A;
      end
      PH_NTT_B: begin
        c.forward  = 1'b1;
        c.src_bank = BANK_B;
      end
      PH_PWMUL: begin
        c.element_wise = 1'b1;
        c.src_bank     = BANK_A;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Phase that follows a completed phase. B's transform is skipped when the
  // operand was handed over already in the NTT domain.
  function automatic phase_e next_phase_of(input phase_e ph, input logic skip_b);
    phase_e n;
    case (ph)
      PH_NTT_A: n = skip_b ? PH_PWMUL : PH_NTT_B;
      PH_NTT_B: n = PH_PWMUL;
      PH_PWMUL: n = PH_INTT;
      default:  n = PH_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/poly_phase_counter.sv
// Cycle counter for one scheduler phase, with timeout compare.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to 0 on the next edge (has priority)
//   enable     : count up by one per cycle, wrapping at 2^WIDTH
//   count      : registered cycle index within the phase
//   timeout    : enable high and count has reached LIMIT
module poly_phase_counter #(
  parameter int WIDTH = 12,
  parameter int LIMIT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign timeout = enable && (count == LIMIT_W);

endmodule

// File: rtl/polynomial_multiplication_scheduler.sv
// Phase sequencer for an NTT-based polynomial multiply:
// NTT(A) -> NTT(B) -> pointwise multiply -> inverse NTT.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   PH_IDLE  | waiting for cmd_valid, cmd_ready high
//   PH_NTT_A | forward transform of operand A (bank 0)
//   PH_NTT_B | forward transform of operand B (bank 1), skippable
//   PH_PWMUL | pointwise multiply
//   PH_INTT  | inverse transform, done pulses after it completes
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid           : multiply request, accepted while cmd_ready
//   cmd_skip_ntt_b      : B already transformed, latched on accept
//   cmd_ready           : high in IDLE only (decoded from the phase register)
//   start               : one-cycle pulse in the first cycle of every phase
//   state               : cycle index within the current phase
//   forward             : 1 = forward NTT, 0 = inverse
//   element_wise        : pointwise multiply phase
//   src_bank            : operand bank, 0 = A, 1 = B
//   stage_done          : phase-complete pulse from the output stage
//   busy                : high outside IDLE
//   done                : one-cycle pulse after a successful multiply
//   error               : sticky phase timeout, cleared by the next accept
module polynomial_multiplication_scheduler
  import poly_mul_pkg::*;
#(
  parameter int PHASE_TIMEOUT = DEFAULT_PHASE_TIMEOUT,
  parameter int STATE_W       = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic               cmd_skip_ntt_b,
  output logic               cmd_ready,
  output logic               start,
  output logic [STATE_W-1:0] state,
  output logic               forward,
  output logic               element_wise,
  output logic [1:0]         src_bank,
  input  logic               stage_done,
  output logic               busy,
  output logic               done,
  output logic               error
);

  phase_e      phase;
  phase_e      phase_nxt;
  phase_ctrl_t ctrl_nxt;
  logic        skip_b;
  logic        timeout;
  logic        cnt_clear;
  logic        cnt_enable;

  // stage_done is checked before the timeout so a completion landing on the
  // limit cycle still counts as a normal advance.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE: begin
        if (cmd_valid) phase_nxt = PH_NTT_A;
      end
      default: begin
        if (stage_done)   phase_nxt = next_phase_of(phase, skip_b);
        else if (timeout) phase_nxt = PH_IDLE;
      end
    endcase
  end

  assign ctrl_nxt   = phase_ctrl(phase_nxt);
  assign cnt_enable = (phase != PH_IDLE);
  // Restart the count on every phase change so each phase begins at 0.
  assign cnt_clear  = (phase == PH_IDLE) || (phase_nxt != phase);

  poly_phase_counter #(
    .WIDTH (STATE_W),
    .LIMIT (PHASE_TIMEOUT)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (state),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PH_IDLE;
      skip_b       <= 1'b0;
      start        <= 1'b0;
      forward      <= 1'b0;
      element_wise <= 1'b0;
      src_bank     <= BANK_A;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      // No phase follows itself, so any change into a non-IDLE phase is a start.
      start        <= (phase_nxt != phase) && (phase_nxt != PH_IDLE);
      forward      <= ctrl_nxt.forward;
      element_wise <= ctrl_nxt.element_wise;
      src_bank     <= ctrl_nxt.src_bank;
      busy         <= (phase_nxt != PH_IDLE);
      done         <= (phase == PH_INTT) && stage_done;
      if (phase == PH_IDLE && cmd_valid) begin
        skip_b <= cmd_skip_ntt_b;
        error  <= 1'b0;
      end else if (timeout && !stage_done) begin
        error  <= 1'b1;
      end
    end
  end

  assign cmd_ready = (phase == PH_IDLE);

endmodule

// File: tb/tb_polynomial_multiplication_scheduler.sv
module tb_polynomial_multiplication_scheduler;

  localparam int TO = 20;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_skip_ntt_b;
  logic          stage_done;
  logic          cmd_ready;
  logic          start;
  logic [SW-1:0] state;
  logic          forward;
  logic          element_wise;
  logic [1:0]    src_bank;
  logic          busy;
  logic          done;
  logic          error;

  polynomial_multiplication_scheduler #(
    .PHASE_TIMEOUT (TO),
    .STATE_W       (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_skip_ntt_b (cmd_skip_ntt_b),
    .cmd_ready      (cmd_ready),
    .start          (start),
    .state          (state),
    .forward        (forward),
    .element_wise   (element_wise),
    .src_bank       (src_bank),
    .stage_done     (stage_done),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: phase numbers 0 idle, 1 NTT A, 2 NTT B, 3 pointwise,
  // 4 inverse. A command loads the list of phases still to run.
  int m_phase = 0;
  int m_state = 0;
  bit m_start = 0;
  bit m_done  = 0;
  bit m_error = 0;
  int m_plan[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_plan.delete();
      m_phase = 0; m_state = 0; m_start = 0; m_done = 0; m_error = 0;
    end else begin
      m_start = 0;
      m_done  = 0;
      if (m_phase == 0) begin
        if (cmd_valid) begin
          m_plan.delete();
          m_plan.push_back(1);
          if (!cmd_skip_ntt_b) m_plan.push_back(2);
          m_plan.push_back(3);
          m_plan.push_back(4);
          m_phase = m_plan.pop_front();
          m_state = 0;
          m_start = 1;
          m_error = 0;
        end
      end else if (stage_done) begin
        m_state = 0;
        if (m_plan.size() == 0) begin
          m_phase = 0;
          m_done  = 1;
        end else begin
          m_phase = m_plan.pop_front();
          m_start = 1;
        end
      end else if (m_state == TO) begin
        m_plan.delete();
        m_phase = 0;
        m_state = 0;
        m_error = 1;
      end else begin
        m_state = (m_state + 1) % (1 << SW);
      end
    end
  end

  // {forward, element_wise, src_bank} for a phase number
  function automatic logic [3:0] exp_ctrl(input int ph);
    case (ph)
      1:       return 4'b1000;
      2:       return 4'b1001;
      3:       return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  int starts[$];
  int dones[$];
  int err_rises[$];
  bit bank1_seen = 0;
  bit prev_err   = 0;
  logic [SW+8:0] exp_v;
  logic [SW+8:0] act_v;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      exp_v = {SW'(m_state), m_start, exp_ctrl(m_phase), (m_phase != 0), m_done, m_error, (m_phase == 0)};
      act_v = {state, start, forward, element_wise, src_bank, busy, done, error, cmd_ready};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_check cyc=%0d actual=%h expected=%h", cyc, act_v, exp_v);
      end
      if (start === 1'b1) starts.push_back(cyc - t_ref);
      if (done === 1'b1) dones.push_back(cyc - t_ref);
      if (src_bank == 2'd1) bank1_seen = 1;
      if (error === 1'b1 && !prev_err) err_rises.push_back(cyc - t_ref);
      prev_err = (error === 1'b1);
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_records();
    starts.delete();
    dones.delete();
    err_rises.delete();
    bank1_seen = 0;
  endtask

  // Drive inputs for the coming edge; stage_done answers at state sd_at in
  // every active phase except hold_ph.
  task automatic drive(input bit v, input bit skip, input int sd_at, input int hold_ph, input bit sd_force);
    @(negedge clk);
    cmd_valid      = v;
    cmd_skip_ntt_b = skip;
    stage_done     = sd_force || (m_phase != 0 && m_phase != hold_ph && m_state == sd_at);
  endtask

  task automatic run(input bit skip, input int sd_at, input int hold_ph, input int v_cycles, input int n);
    for (int i = 0; i < n; i++) begin
      drive(i < v_cycles, skip, sd_at, hold_ph, 1'b0);
      if (i == 0) begin
        t_ref = cyc;
        clear_records();
      end
    end
    drive(1'b0, 1'b0, -1, -1, 1'b0);
    #2;
  endtask

  bit found;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_skip_ntt_b = 1'b0; stage_done = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_int("reset_flags", int'({start, forward, element_wise, src_bank, busy, done, error, cmd_ready}), 1);
    check_int("reset_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // stray stage_done in IDLE
    clear_records();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, -1, -1, 1'b1);
    drive(1'b0, 1'b0, -1, -1, 1'b0);
    #2;
    check_int("stray_no_start", starts.size(), 0);
    check_int("stray_busy", int'(busy), 0);

    // full sequence, done at state 9 of each phase
    run(1'b0, 9, -1, 1, 45);
    check_int("seq_n_starts", starts.size(), 4);
    check_int("seq_start0", starts[0], 1);
    check_int("seq_start1", starts[1], 11);
    check_int("seq_start2", starts[2], 21);
    check_int("seq_start3", starts[3], 31);
    check_int("seq_n_done", dones.size(), 1);
    check_int("seq_done", dones[0], 41);
    check_int("seq_bank_b", int'(bank1_seen), 1);

    // B already in NTT domain
    run(1'b1, 9, -1, 1, 45);
    check_int("skip_n_starts", starts.size(), 3);
    check_int("skip_start2", starts[2], 21);
    check_int("skip_done", dones[0], 31);
    check_int("skip_bank_b", int'(bank1_seen), 0);

    // pointwise phase never completes
    run(1'b0, 9, 3, 1, 50);
    check_int("to_n_starts", starts.size(), 3);
    check_int("to_err_rise", err_rises[0], 42);
    check_int("to_no_done", dones.size(), 0);
    check_int("to_err_held", int'(error), 1);
    check_int("to_idle", int'(cmd_ready), 1);
    run(1'b0, 9, -1, 1, 45);
    check_int("to_recover_done", dones[0], 41);
    check_int("to_recover_err", int'(error), 0);

    // stage_done on the timeout cycle
    run(1'b0, TO, -1, 1, 90);
    check_int("tie_start3", starts[3], 64);
    check_int("tie_done", dones[0], 85);
    check_int("tie_no_err", err_rises.size(), 0);

    // cmd_valid held high across a completion
    run(1'b0, 9, -1, 50, 85);
    check_int("held_n_starts", starts.size(), 8);
    check_int("held_restart", starts[4], 42);
    check_int("held_n_done", dones.size(), 2);
    check_int("held_done1", dones[1], 82);

    // reset during NTT_B at state 5
    drive(1'b1, 1'b0, 9, -1, 1'b0);
    t_ref = cyc;
    clear_records();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(1'b0, 1'b0, 9, -1, 1'b0);
      if (m_phase == 2 && m_state == 5) found = 1;
    end
    check_int("rst_found", int'(found), 1);
    check_int("rst_at_cycle", cyc - t_ref, 16);
    rst_n = 1'b0;
    #1;
    check_int("rst_mid_flags", int'({start, forward, element_wise, src_bank, busy, done, error, cmd_ready}), 1);
    check_int("rst_mid_state", int'(state), 0);
    drive(1'b0, 1'b0, -1, -1, 1'b0);
    drive(1'b0, 1'b0, -1, -1, 1'b0);
    drive(1'b1, 1'b0, 9, -1, 1'b0);
    rst_n = 1'b1;
    t_ref = cyc;
    clear_records();
    for (int i = 0; i < 44; i++) drive(1'b0, 1'b0, 9, -1, 1'b0);
    #2;
    check_int("rst_rel_start0", starts[0], 1);
    check_int("rst_rel_done", dones[0], 41);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      cmd_valid      = ($urandom_range(0, 3) == 0);
      cmd_skip_ntt_b = $urandom_range(0, 1) == 1;
      stage_done     = ($urandom_range(0, 23) < ((i < 400) ? 4 : 1));
    end
    @(negedge clk);
    rst_n = 1'b1; cmd_valid = 1'b0; stage_done = 1'b0;
    repeat (3) @(negedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
